vga_text_writer: RTL

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

---
 rtl/vga_text_writer_if.sv | 47 ++++
 rtl/vga_text_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_writer_if.sv
// Command and RAM-write bundle for vga_text_writer.
// Latency: none; wires only.
// Backpressure: cmd_valid/cmd_ready handshake; RAM write side has no backpressure.
//
// Signals:
//   cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_char, cmd_color : command from master
//   cmd_ready, busy, cmd_err                                           : status to master
//   wren, wrencolor, wraddress, wrdata, wcolor                         : text/colour RAM writes
//   wrencursor, wcursorAddress, wcursor                                : cursor RAM writes
// The master modport drives commands and observes everything else.
// The slave modport belongs to the writer block.
interface vga_text_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [6:0]  cmd_w;
  logic [5:0]  cmd_h;
  logic [7:0]  cmd_char;
  logic [7:0]  cmd_color;
  logic        busy;
  logic        cmd_err;

  logic        wren;
  logic        wrencolor;
  logic [11:0] wraddress;
  logic [7:0]  wrdata;
  logic [7:0]  wcolor;
  logic        wrencursor;
  logic [1:0]  wcursorAddress;
  logic [7:0]  wcursor;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_char, cmd_color,
    input  cmd_ready, busy, cmd_err,
    input  wren, wrencolor, wraddress, wrdata, wcolor,
    input  wrencursor, wcursorAddress, wcursor
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_char, cmd_color,
    output cmd_ready, busy, cmd_err,
    output wren, wrencolor, wraddress, wrdata, wcolor,
    output wrencursor, wcursorAddress, wcursor
  );
endinterface

// File: rtl/vga_text_writer.sv
// Text-mode VGA writer: executes PUT / FILL / CURSOR / CLEAR commands as text, colour and cursor RAM writes.
// Latency: first write appears in the cycle after acceptance; one write per cycle thereafter.
// Backpressure: cmd_ready is high only when idle; a held cmd_valid waits until the current command ends.
//
// Ports:
//   clk25MHz : single rising-edge clock
//   reset    : synchronous, active-high; aborts any command in progress
//   bus      : vga_text_writer_if.slave (command handshake, status, RAM write ports)
// Optional feature: define VGA_TEXT_WRITER_FILL_EN to build the rectangular FILL engine.
// Without it, FILL (op 01) is rejected with a cmd_err pulse and writes nothing.
module vga_text_writer #(
  parameter int         COLS        = 80,
  parameter int         ROWS        = 40,
  parameter logic [7:0] CLEAR_COLOR = 8'hF2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic            clk25MHz,
  input  logic            reset,
  vga_text_writer_if.slave bus
);

  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS_A    = 12'(COLS);
  localparam logic [7:0]  COLS_W    = 8'(COLS);
  localparam logic [6:0]  ROWS_W    = 7'(ROWS);

  localparam logic [1:0] OP_PUT    = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_CURSOR = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

`ifdef VGA_TEXT_WRITER_FILL_EN
  typedef enum logic [2:0] {IDLE, PUT, FILL, CUR_X, CUR_Y, CLEAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, PUT, CUR_X, CUR_Y, CLEAR} state_t;
`endif

  // Row-major cell address; always within 0..COLS*ROWS-1 when callers range-check first.
  function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return 12'(row) * COLS_A + 12'(col);
  endfunction

  state_t      state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wraddress_q, wraddress_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic [7:0]  wcolor_q, wcolor_d;
  logic        cur_en_q, cur_en_d;
  logic [1:0]  cur_addr_q, cur_addr_d;
  logic [7:0]  cur_data_q, cur_data_d;
  logic [5:0]  cur_y_q, cur_y_d;
  logic        err_q, err_d;

  logic ready;
  logic accept;
  logic x_ok;
  logic y_ok;

  assign ready  = (state_q == IDLE) && !reset;
  assign accept = bus.cmd_valid && ready;
  assign x_ok   = ({1'b0, bus.cmd_x} < COLS_W);
  assign y_ok   = ({1'b0, bus.cmd_y} < ROWS_W);

`ifdef VGA_TEXT_WRITER_FILL_EN
  // Rectangle bookkeeping. The end bounds are clipped to the screen on
  // acceptance so stepping never has to visit (or skip over) off-screen cells.
  logic [6:0] fill_x0_q, fill_x0_d;
  logic [6:0] fill_col_q, fill_col_d;
  logic [5:0] fill_row_q, fill_row_d;
  logic [7:0] fill_ecol_q, fill_ecol_d;
  logic [6:0] fill_erow_q, fill_erow_d;

  logic [7:0] fill_xend;
  logic [6:0] fill_yend;
  logic       fill_ok;

  assign fill_xend = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
  assign fill_yend = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
  assign fill_ok   = (bus.cmd_w != 7'd0) && (bus.cmd_h != 6'd0) && x_ok && y_ok;
`else
  logic unused_fill_fields;
  assign unused_fill_fields = ^{bus.cmd_w, bus.cmd_h};
`endif

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wraddress_d = wraddress_q;
    wrdata_d    = wrdata_q;
    wcolor_d    = wcolor_q;
    cur_en_d    = 1'b0;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    cur_y_d     = cur_y_q;
    err_d       = 1'b0;
`ifdef VGA_TEXT_WRITER_FILL_EN
    fill_x0_d   = fill_x0_q;
    fill_col_d  = fill_col_q;
    fill_row_d  = fill_row_q;
    fill_ecol_d = fill_ecol_q;
    fill_erow_d = fill_erow_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_PUT: begin
              // PUT always spends one cycle in PUT; the write or the error
              // pulse is presented during that cycle.
              state_d = PUT;
              if (x_ok && y_ok) begin
                wr_en_d     = 1'b1;
                wraddress_d = cell_addr(bus.cmd_y, bus.cmd_x);
                wrdata_d    = bus.cmd_char;
                wcolor_d    = bus.cmd_color;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_FILL: begin
`ifdef VGA_TEXT_WRITER_FILL_EN
              state_d = FILL;
              if (fill_ok) begin
                wr_en_d     = 1'b1;
                wraddress_d = cell_addr(bus.cmd_y, bus.cmd_x);
                wrdata_d    = bus.cmd_char;
                wcolor_d    = bus.cmd_color;
                fill_x0_d   = bus.cmd_x;
                fill_col_d  = bus.cmd_x;
                fill_row_d  = bus.cmd_y;
                fill_ecol_d = (fill_xend > COLS_W) ? COLS_W : fill_xend;
                fill_erow_d = (fill_yend > ROWS_W) ? ROWS_W : fill_yend;
              end
`else
              // Unsupported in this build: reuse the one-cycle PUT path as a reject.
              state_d = PUT;
              err_d   = 1'b1;
`endif
            end
            OP_CURSOR: begin
              state_d    = CUR_X;
              cur_en_d   = 1'b1;
              cur_addr_d = 2'd0;
              cur_data_d = {1'b0, bus.cmd_x};
              cur_y_d    = bus.cmd_y;
            end
            default: begin
              state_d     = CLEAR;
              wr_en_d     = 1'b1;
              wraddress_d = 12'd0;
              wrdata_d    = CLEAR_CHAR;
              wcolor_d    = CLEAR_COLOR;
            end
          endcase
        end
      end

      PUT: state_d = IDLE;

`ifdef VGA_TEXT_WRITER_FILL_EN
      FILL: begin
        // A degenerate FILL enters with no write pending; it just returns.
        // Otherwise the cell shown this cycle is (fill_col_q, fill_row_q).
        if (!wr_en_q) begin
          state_d = IDLE;
        end else if (({1'b0, fill_col_q} + 8'd1) < fill_ecol_q) begin
          fill_col_d  = fill_col_q + 7'd1;
          wr_en_d     = 1'b1;
          wraddress_d = cell_addr(fill_row_q, fill_col_q + 7'd1);
        end else if (({1'b0, fill_row_q} + 7'd1) < fill_erow_q) begin
          fill_col_d  = fill_x0_q;
          fill_row_d  = fill_row_q + 6'd1;
          wr_en_d     = 1'b1;
          wraddress_d = cell_addr(fill_row_q + 6'd1, fill_x0_q);
        end else begin
          state_d = IDLE;
        end
      end
`endif

      CUR_X: begin
        state_d    = CUR_Y;
        cur_en_d   = 1'b1;
        cur_addr_d = 2'd1;
        cur_data_d = {2'b00, cur_y_q};
      end

      CUR_Y: state_d = IDLE;

      CLEAR: begin
        // wraddress_q doubles as the sweep counter.
        if (wraddress_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          wr_en_d     = 1'b1;
          wraddress_d = wraddress_q + 12'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      wraddress_q <= 12'd0;
      wrdata_q    <= 8'd0;
      wcolor_q    <= 8'd0;
      cur_en_q    <= 1'b0;
      cur_addr_q  <= 2'd0;
      cur_data_q  <= 8'd0;
      cur_y_q     <= 6'd0;
      err_q       <= 1'b0;
`ifdef VGA_TEXT_WRITER_FILL_EN
      fill_x0_q   <= 7'd0;
      fill_col_q  <= 7'd0;
      fill_row_q  <= 6'd0;
      fill_ecol_q <= 8'd0;
      fill_erow_q <= 7'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wraddress_q <= wraddress_d;
      wrdata_q    <= wrdata_d;
      wcolor_q    <= wcolor_d;
      cur_en_q    <= cur_en_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      cur_y_q     <= cur_y_d;
      err_q       <= err_d;
`ifdef VGA_TEXT_WRITER_FILL_EN
      fill_x0_q   <= fill_x0_d;
      fill_col_q  <= fill_col_d;
      fill_row_q  <= fill_row_d;
      fill_ecol_q <= fill_ecol_d;
      fill_erow_q <= fill_erow_d;
`endif
    end
  end

  // busy is the complement of cmd_ready except while reset holds both low.
  assign bus.cmd_ready      = ready;
  assign bus.busy           = (state_q != IDLE) && !reset;
  assign bus.cmd_err        = err_q;
  assign bus.wren           = wr_en_q;
  assign bus.wrencolor      = wr_en_q;
  assign bus.wraddress      = wraddress_q;
  assign bus.wrdata         = wrdata_q;
  assign bus.wcolor         = wcolor_q;
  assign bus.wrencursor     = cur_en_q;
  assign bus.wcursorAddress = cur_addr_q;
  assign bus.wcursor        = cur_data_q;

endmodule
